pll_reset_sequencer: RTL
========================

// Module: pll_reset_sequencer
// PURPOSE
//  Consumer end of the PLL lock interface: runs on the PLL output clock (80 MHz), synchronizes
//  the asynchronous 'locked' flag and an active-low reset button, and produces the system reset.
//  System reset is released only after lock has been stable and a hold period has elapsed.
//  Reset is re-asserted on lock loss or button press. Sits between the pll wrapper and the SoC top.
// PARAMETERS
//  SYNC_STAGES         2       flops in each synchronizer (>=2)
//  LOCK_STABLE_CYCLES  8000    cycles locked_sync must stay high before HOLD (100 us @80 MHz)
//  RESET_HOLD_CYCLES   64      cycles sys_reset stays asserted after lock is qualified
//  DEBOUNCE_CYCLES     800000  cycles button must be stable to be accepted (10 ms)
// PORTS
//  clk            in   1  PLL output clock (single clock domain)
//  reset          in   1  synchronous, active-high power-on reset of this block
//  locked         in   1  PLL lock, asynchronous to clk
//  btn_n          in   1  reset button, active-low, asynchronous, bouncing
//  lock_loss_clr  in   1  clears lock-loss counter/sticky flag (sync, 1-cycle pulse)
//  sys_reset      out  1  system reset, active-high, registered
//  sys_reset_n    out  1  registered complement of sys_reset
//  ready          out  1  high in S_RUN only
//  state_o        out  2  current FSM state encoding
//  lock_loss_cnt  out  8  saturating lock-loss event count
//  lock_lost      out  1  sticky: lock lost at least once while in S_RUN
// BEHAVIOUR
//  - One clock, clk. reset is synchronous and active-high. While reset=1 at an edge:
//    state=S_WAIT_LOCK, sys_reset=1, sys_reset_n=0, ready=0, counters=0, synchronizers=0,
//    debounced button=released.
//  - locked_sync is 'locked' through SYNC_STAGES flops. btn_n goes through SYNC_STAGES flops,
//    then the debouncer. The debounce counter restarts on every change of the synced value.
//    btn_db updates after DEBOUNCE_CYCLES consecutive equal samples.
//    btn_press is a 1-cycle pulse on the btn_db released->pressed transition.
//  - FSM (encodings 0..3), one shared counter cnt:
//    S_WAIT_LOCK: sys_reset=1; locked_sync=1 -> S_STABLE, cnt=0.
//    S_STABLE:    sys_reset=1; locked_sync=0 -> S_WAIT_LOCK; cnt==LOCK_STABLE_CYCLES-1 -> S_HOLD, cnt=0.
//    S_HOLD:      sys_reset=1; locked_sync=0 -> S_WAIT_LOCK; btn_press -> cnt=0 (restart hold);
//                 cnt==RESET_HOLD_CYCLES-1 -> S_RUN.
//    S_RUN:       sys_reset=0, ready=1; locked_sync=0 -> S_WAIT_LOCK (lock-loss event);
//                 btn_press -> S_HOLD, cnt=0.
//  - Priority when events coincide: lock loss > btn_press > counter terminal.
//  - sys_reset/ready are registered from next-state, so they change on the same edge as state.
//  - Latency: if 'locked' is first sampled high at edge 0 and stays high, sys_reset falls on
//    edge SYNC_STAGES+LOCK_STABLE_CYCLES+RESET_HOLD_CYCLES. Lock loss in S_RUN asserts
//    sys_reset SYNC_STAGES edges after 'locked' is first sampled low.
//  - Any glitch of locked_sync low during S_STABLE/S_HOLD restarts qualification from S_WAIT_LOCK.
//  - A btn_press in S_WAIT_LOCK/S_STABLE is ignored. The button is level-held in the debouncer,
//    so a long press yields one press.
//  - cnt width is $clog2(max(LOCK_STABLE_CYCLES,RESET_HOLD_CYCLES)). cnt never wraps.
// CONFIGURATION
//  `PLL_LOCK_LOSS_CNT_EN defined:
//    - lock_loss_cnt increments on each S_RUN->S_WAIT_LOCK lock-loss event and saturates at 255.
//    - lock_lost sets on the same event.
//    - lock_loss_clr zeroes both. Clear wins over a simultaneous increment.
//    - Both are reset to 0 by reset.
//  Not defined: lock_loss_cnt=8'd0, lock_lost=0 constant. lock_loss_clr is ignored. No counter logic.
// STRUCTURE
//  - Package pll_rst_pkg: state enum S_WAIT_LOCK=0, S_STABLE=1, S_HOLD=2, S_RUN=3;
//    LOSS_CNT_W=8.
//  - Sub-module rst_debounce (SYNC_STAGES, DEBOUNCE_CYCLES): synchronizer + debouncer,
//    outputs btn_db and btn_press.
//  - Top holds the FSM, the shared counter and the optional loss counter.
// TESTING  (bench params: SYNC=2, LOCK_STABLE=16, HOLD=4, DEBOUNCE=8)
//  1 reset=1 for 3 cycles, locked=0 -> sys_reset=1, sys_reset_n=0, ready=0, state_o=0 throughout.
//  2 locked rises, held high -> sys_reset falls exactly at edge 22, ready=1, state_o=3.
//  3 locked low for 1 cycle at edge 10 of qualification -> state_o returns to 0; release slips
//    to 22 edges after re-lock.
//  4 In S_RUN, btn_n bounces 3 times then held low 20 cycles -> exactly one S_HOLD entry;
//    sys_reset high for 4 cycles, then S_RUN.
//  5 In S_RUN, drop locked -> sys_reset=1 two edges later, state_o=0.
//    With `PLL_LOCK_LOSS_CNT_EN: lock_loss_cnt=1, lock_lost=1.
//  6 With EN: 300 lock-loss events -> cnt=255. Pulse lock_loss_clr together with a loss event
//    -> cnt=0, lock_lost=0.
//    Without EN: cnt stays 0, lock_lost stays 0.

Source files
------------

// File: rtl/pll_rst_pkg.sv
// Shared types for the PLL reset sequencer: FSM state encoding and loss counter width.
package pll_rst_pkg;

   typedef enum logic [1:0] {
      S_WAIT_LOCK = 2'd0,
      S_STABLE    = 2'd1,
      S_HOLD      = 2'd2,
      S_RUN       = 2'd3
   } state_t;

   localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/rst_debounce.sv
// Reset-button conditioning: synchronizes the active-low button into clk, debounces it,
// and emits a single-cycle pulse when the debounced level goes from released to pressed.
module rst_debounce #(
   parameter int SYNC_STAGES     = 2,
   parameter int DEBOUNCE_CYCLES = 800000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_n,
   output logic btn_db,
   output logic btn_press
);

   localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_TERM = DB_W'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic [DB_W-1:0]        db_cnt;
   logic                   btn_sync;

   assign btn_sync = sync_q[SYNC_STAGES-1];

   // The counter only runs while the synced level disagrees with the accepted level,
   // so any bounce back to the accepted level restarts the qualification window.
   always_ff @(posedge clk) begin
      if (reset) begin
         sync_q    <= '0;
         db_cnt    <= '0;
         btn_db    <= 1'b1;
         btn_press <= 1'b0;
      end else begin
         sync_q    <= {sync_q[SYNC_STAGES-2:0], btn_n};
         btn_press <= 1'b0;
         if (btn_sync == btn_db) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_TERM) begin
            btn_db    <= btn_sync;
            btn_press <= ~btn_sync;
            db_cnt    <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
      end
   end

endmodule

// File: rtl/pll_reset_sequencer.sv
// System reset sequencer on the PLL output clock: qualifies lock, holds reset, reacts to
// lock loss and the reset button. Define PLL_LOCK_LOSS_CNT_EN to build the lock-loss counter.
module pll_reset_sequencer
   import pll_rst_pkg::*;
#(
   parameter int SYNC_STAGES        = 2,
   parameter int LOCK_STABLE_CYCLES = 8000,
   parameter int RESET_HOLD_CYCLES  = 64,
   parameter int DEBOUNCE_CYCLES    = 800000
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  locked,
   input  logic                  btn_n,
   input  logic                  lock_loss_clr,
   output logic                  sys_reset,
   output logic                  sys_reset_n,
   output logic                  ready,
   output logic [1:0]            state_o,
   output logic [LOSS_CNT_W-1:0] lock_loss_cnt,
   output logic                  lock_lost
);

   localparam int CNT_MAX = (LOCK_STABLE_CYCLES > RESET_HOLD_CYCLES) ? LOCK_STABLE_CYCLES
                                                                     : RESET_HOLD_CYCLES;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] LOCK_TERM = CNT_W'(LOCK_STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] HOLD_TERM = CNT_W'(RESET_HOLD_CYCLES - 1);

   state_t                 state;
   logic [CNT_W-1:0]       cnt;
   logic [SYNC_STAGES-1:0] lock_sync_q;
   logic                   locked_sync;
   logic                   btn_press;
   logic                   btn_db_unused;

   assign locked_sync = lock_sync_q[SYNC_STAGES-1];
   assign state_o     = state;

   always_ff @(posedge clk) begin
      if (reset) begin
         lock_sync_q <= '0;
      end else begin
         lock_sync_q <= {lock_sync_q[SYNC_STAGES-2:0], locked};
      end
   end

   rst_debounce #(
      .SYNC_STAGES     (SYNC_STAGES),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk       (clk),
      .reset     (reset),
      .btn_n     (btn_n),
      .btn_db    (btn_db_unused),
      .btn_press (btn_press)
   );

   // Outputs are assigned alongside each state change so they track the state register
   // exactly; lock loss is tested first in every state, then the button, then the counter.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= S_WAIT_LOCK;
         cnt         <= '0;
         sys_reset   <= 1'b1;
         sys_reset_n <= 1'b0;
         ready       <= 1'b0;
      end else begin
         case (state)
            S_WAIT_LOCK: begin
               if (locked_sync) begin
                  state <= S_STABLE;
                  cnt   <= '0;
               end
            end
            S_STABLE: begin
               if (!locked_sync) begin
                  state <= S_WAIT_LOCK;
               end else if (cnt == LOCK_TERM) begin
                  state <= S_HOLD;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_HOLD: begin
               if (!locked_sync) begin
                  state <= S_WAIT_LOCK;
               end else if (btn_press) begin
                  cnt <= '0;
               end else if (cnt == HOLD_TERM) begin
                  state       <= S_RUN;
                  sys_reset   <= 1'b0;
                  sys_reset_n <= 1'b1;
                  ready       <= 1'b1;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            S_RUN: begin
               if (!locked_sync) begin
                  state       <= S_WAIT_LOCK;
                  sys_reset   <= 1'b1;
                  sys_reset_n <= 1'b0;
                  ready       <= 1'b0;
               end else if (btn_press) begin
                  state       <= S_HOLD;
                  cnt         <= '0;
                  sys_reset   <= 1'b1;
                  sys_reset_n <= 1'b0;
                  ready       <= 1'b0;
               end
            end
            default: begin
               state       <= S_WAIT_LOCK;
               sys_reset   <= 1'b1;
               sys_reset_n <= 1'b0;
               ready       <= 1'b0;
            end
         endcase
      end
   end

`ifdef PLL_LOCK_LOSS_CNT_EN
   logic loss_event;

   assign loss_event = (state == S_RUN) && !locked_sync;

   // Clear has priority so software never misses a zeroing on a coincident loss.
   always_ff @(posedge clk) begin
      if (reset || lock_loss_clr) begin
         lock_loss_cnt <= '0;
         lock_lost     <= 1'b0;
      end else if (loss_event) begin
         if (lock_loss_cnt != '1) begin
            lock_loss_cnt <= lock_loss_cnt + 1'b1;
         end
         lock_lost <= 1'b1;
      end
   end
`else
   logic clr_unused;

   assign clr_unused    = lock_loss_clr;
   assign lock_loss_cnt = '0;
   assign lock_lost     = 1'b0;
`endif

endmodule
